// File: rtl/ps2_scancode_rx_pkg.sv
// Shared definitions for the PS/2 scancode receiver: FSM encoding,
// protocol prefix bytes and default filter/timeout settings.
package ps2_scancode_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  localparam int PS2_FILTER_LEN_DEF = 8;
  localparam int PS2_TIMEOUT_DEF    = 8000;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus stability filter for the PS/2 clock line;
// emits a one-cycle strobe in the first cycle the filtered level is low.
module ps2_line_filter
  import ps2_scancode_rx_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          line_p0;
  logic          line_p1;
  logic          filt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_p0 <= 1'b1;
      line_p1 <= 1'b1;
      filt    <= 1'b1;
      cnt     <= '0;
      fall    <= 1'b0;
    end else begin
      line_p0 <= line;
      line_p1 <= line_p0;
      fall    <= 1'b0;
      // cnt tracks how many consecutive samples disagree with filt
      if (line_p1 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= line_p1;
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames bytes off the filtered PS/2 clock and folds
// E0/F0 prefixes into extended/released flags on the following scancode.
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       code_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic          frame_ok, frame_bad;
  logic          fall, timeout;
  logic          data_p0, data_p1;
  logic [TW-1:0] to_cnt;
  logic          pend_ext, pend_rel;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .line  (clkps2),
    .fall  (fall)
  );

  // A real sample point in the same cycle wins over an expiring timeout
  assign timeout = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES)) && !fall;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (timeout) begin
      state_n   = ST_IDLE;
      frame_bad = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!data_p1) begin
            state_n   = ST_DATA;
            bit_cnt_n = 3'd0;
          end
        end
        ST_DATA: begin
          shift_n   = {data_p1, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          par_n   = data_p1;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (data_p1 && (^{shift, par})) frame_ok  = 1'b1;
          else                            frame_bad = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
      data_p0 <= dataps2;
      data_p1 <= data_p0;
      if (state == ST_IDLE || fall)        to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TW'(1);
    end
  end

  // Output stage: registered one cycle after the stop sample or error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scancode    <= 8'h00;
      extended    <= 1'b0;
      released    <= 1'b0;
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
      pend_ext    <= 1'b0;
      pend_rel    <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (frame_bad) begin
        frame_error <= 1'b1;
        pend_ext    <= 1'b0;
        pend_rel    <= 1'b0;
      end else if (frame_ok) begin
        if (shift == PS2_PREFIX_EXT) begin
          pend_ext <= 1'b1;
        end else if (shift == PS2_PREFIX_REL) begin
          pend_rel <= 1'b1;
        end else begin
          scancode   <= shift;
          extended   <= pend_ext;
          released   <= pend_rel;
          code_valid <= 1'b1;
          pend_ext   <= 1'b0;
          pend_rel   <= 1'b0;
        end
      end
    end
  end

endmodule
